// File: rtl/mmu_bus_pkg.sv
// Shared types and constants for the MMU-side memory bus arbiter.
package mmu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    localparam logic       PORT_I       = 1'b0;
    localparam logic       PORT_D       = 1'b1;
    localparam logic [3:0] BYTESEL_WORD = 4'b1111;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter that flags the cycle in which an outstanding
// memory access has waited TIMEOUT cycles. TIMEOUT = 0 disables it.
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    // A zero-width counter is illegal, so the disabled case keeps one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q;

    // Count waiting cycles; stop at TIMEOUT instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Expire in the waiting cycle whose clock edge brings the count to
    // TIMEOUT, so the abort is taken at that same edge.
    assign expire_o = (TIMEOUT != 0) && enable_i && (count_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter joining the instruction and data uncached request
// ports onto one registered request/acknowledge memory bus, with a
// timeout abort that reports a bus error.
//
// Handshake: a port raises en with stable operands and holds them until
// its ready pulses for one cycle. Toward memory, mem_req_o rises with the
// latched operands and stays high (operands stable) until the cycle in
// which mem_ack_i is seen; mem_rdata_i is taken in that same cycle.
module mem_bus_arbiter
    import mmu_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ibus_en_i,
    input  logic [ADDR_W-1:0] ibus_addr_i,
    output logic [DATA_W-1:0] ibus_data_o,
    output logic              ibus_ready_o,
    input  logic              dbus_en_i,
    input  logic [ADDR_W-1:0] dbus_addr_i,
    input  logic              dbus_wr_i,
    input  logic [3:0]        dbus_bytesel_i,
    input  logic [DATA_W-1:0] dbus_wdata_i,
    output logic [DATA_W-1:0] dbus_data_o,
    output logic              dbus_ready_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [3:0]        mem_bytesel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              bus_error_o,
    output logic              bus_error_src_o
);

    bus_state_t state_q, state_d;
    // Last-served port; while BUSY/RESP it is also the current grantee.
    logic       last_q;
    logic       pick;
    logic       start;
    logic       ack_evt;
    logic       expire;
    logic       tmo_evt;

    // Lone requester wins; on contention the port not served last wins.
    assign pick    = (ibus_en_i && dbus_en_i) ? ~last_q :
                     (dbus_en_i ? PORT_D : PORT_I);
    assign start   = (state_q == IDLE) && (ibus_en_i || dbus_en_i);
    assign ack_evt = (state_q == BUSY) && mem_ack_i;
    // Ack has priority: the counter is not enabled in an ack cycle.
    assign tmo_evt = expire;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (start),
        .enable_i ((state_q == BUSY) && !mem_ack_i),
        .expire_o (expire)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, finish on ack or timeout, one RESP cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ibus_en_i || dbus_en_i) state_d = BUSY;
            BUSY:    if (mem_ack_i || expire)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus-side registers, per-port results and one-cycle status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q          <= PORT_D;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= '0;
            mem_wr_o        <= 1'b0;
            mem_bytesel_o   <= '0;
            mem_wdata_o     <= '0;
            ibus_data_o     <= '0;
            dbus_data_o     <= '0;
            ibus_ready_o    <= 1'b0;
            dbus_ready_o    <= 1'b0;
            bus_error_o     <= 1'b0;
            bus_error_src_o <= 1'b0;
        end else begin
            ibus_ready_o <= 1'b0;
            dbus_ready_o <= 1'b0;
            bus_error_o  <= 1'b0;
            if (start) begin
                last_q    <= pick;
                mem_req_o <= 1'b1;
                if (pick == PORT_D) begin
                    mem_addr_o    <= dbus_addr_i;
                    mem_wr_o      <= dbus_wr_i;
                    mem_bytesel_o <= dbus_bytesel_i;
                    mem_wdata_o   <= dbus_wdata_i;
                end else begin
                    mem_addr_o    <= ibus_addr_i;
                    mem_wr_o      <= 1'b0;
                    mem_bytesel_o <= BYTESEL_WORD;
                    mem_wdata_o   <= '0;
                end
            end
            if (ack_evt || tmo_evt) begin
                mem_req_o <= 1'b0;
                if (last_q == PORT_D) dbus_ready_o <= 1'b1;
                else                  ibus_ready_o <= 1'b1;
            end
            if (ack_evt && !mem_wr_o) begin
                if (last_q == PORT_D) dbus_data_o <= mem_rdata_i;
                else                  ibus_data_o <= mem_rdata_i;
            end
            if (tmo_evt) begin
                if (last_q == PORT_D) dbus_data_o <= '0;
                else                  ibus_data_o <= '0;
                bus_error_o     <= 1'b1;
                bus_error_src_o <= last_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized
// request/ack rounds, checked against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ibus_en_i;
    logic [AW-1:0] ibus_addr_i;
    logic [DW-1:0] ibus_data_o;
    logic          ibus_ready_o;
    logic          dbus_en_i;
    logic [AW-1:0] dbus_addr_i;
    logic          dbus_wr_i;
    logic [3:0]    dbus_bytesel_i;
    logic [DW-1:0] dbus_wdata_i;
    logic [DW-1:0] dbus_data_o;
    logic          dbus_ready_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wr_o;
    logic [3:0]    mem_bytesel_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          bus_error_o;
    logic          bus_error_src_o;

    // Clock and reset drive.
    always #5 clk_i = ~clk_i;

    mem_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ibus_en_i       (ibus_en_i),
        .ibus_addr_i     (ibus_addr_i),
        .ibus_data_o     (ibus_data_o),
        .ibus_ready_o    (ibus_ready_o),
        .dbus_en_i       (dbus_en_i),
        .dbus_addr_i     (dbus_addr_i),
        .dbus_wr_i       (dbus_wr_i),
        .dbus_bytesel_i  (dbus_bytesel_i),
        .dbus_wdata_i    (dbus_wdata_i),
        .dbus_data_o     (dbus_data_o),
        .dbus_ready_o    (dbus_ready_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wr_o        (mem_wr_o),
        .mem_bytesel_o   (mem_bytesel_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .bus_error_o     (bus_error_o),
        .bus_error_src_o (bus_error_src_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: last served port (0 = I, 1 = D), the two
    // result registers and the held error source.
    int            last_port;
    logic [DW-1:0] iexp;
    logic [DW-1:0] dexp;
    logic          src_exp;
    // Predicted result-register value of each granted transaction.
    logic [DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ireq"},  mem_req_o, 0);
        check_eq({tag, "_addr"},  mem_addr_o, 0);
        check_eq({tag, "_wr"},    mem_wr_o, 0);
        check_eq({tag, "_bsel"},  mem_bytesel_o, 0);
        check_eq({tag, "_wdata"}, mem_wdata_o, 0);
        check_eq({tag, "_idata"}, ibus_data_o, 0);
        check_eq({tag, "_ddata"}, dbus_data_o, 0);
        check_eq({tag, "_irdy"},  ibus_ready_o, 0);
        check_eq({tag, "_drdy"},  dbus_ready_o, 0);
        check_eq({tag, "_err"},   bus_error_o, 0);
        check_eq({tag, "_src"},   bus_error_src_o, 0);
    endtask

    task automatic model_reset();
        last_port = 1;
        iexp      = '0;
        dexp      = '0;
        src_exp   = 1'b0;
        exp_q.delete();
    endtask

    // One arbitration round. Entered and left at a falling edge while the
    // DUT is idle. lat = BUSY cycle (1-based) carrying the ack; lat > TMO
    // means memory never answers. rst_at > 0 pulses reset in that BUSY
    // cycle. served returns the granted port or -1.
    task automatic run_round(input logic ien, input logic [AW-1:0] iaddr,
                             input logic den, input logic [AW-1:0] daddr,
                             input logic dwr, input logic [3:0] dbsel,
                             input logic [DW-1:0] dwdata, input int lat,
                             input logic [DW-1:0] rdata, input logic drop,
                             input int rst_at, output int served);
        int   g;
        logic ackd;
        logic [DW-1:0] pred;
        logic [DW-1:0] got;
        ibus_en_i      = ien;
        ibus_addr_i    = iaddr;
        dbus_en_i      = den;
        dbus_addr_i    = daddr;
        dbus_wr_i      = dwr;
        dbus_bytesel_i = dbsel;
        dbus_wdata_i   = dwdata;
        served         = -1;
        check_eq("idle_req", mem_req_o, 0);
        check_eq("idle_rdy", {ibus_ready_o, dbus_ready_o}, 0);
        check_eq("idle_err", bus_error_o, 0);
        if (!ien && !den) begin
            @(negedge clk_i);
            check_eq("noreq_req", mem_req_o, 0);
            return;
        end
        if (ien && den) g = 1 - last_port;
        else            g = ien ? 0 : 1;
        last_port = g;
        served    = g;
        ackd      = (lat <= TMO);
        if (!ackd)          pred = '0;
        else if (g == 1 && dwr) pred = dexp;
        else                pred = rdata;
        exp_q.push_back(pred);
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk_i);
            check_eq("busy_req", mem_req_o, 1);
            check_eq("busy_addr", mem_addr_o, (g == 0) ? iaddr : daddr);
            check_eq("busy_wr", mem_wr_o, (g == 0) ? 1'b0 : dwr);
            check_eq("busy_bsel", mem_bytesel_o, (g == 0) ? 4'hF : dbsel);
            if (g == 1) check_eq("busy_wdata", mem_wdata_o, dwdata);
            check_eq("busy_rdy", {ibus_ready_o, dbus_ready_o}, 0);
            check_eq("busy_err", bus_error_o, 0);
            if (c == rst_at) begin
                rst_i = 1'b1;
                #1;
                check_reset("rst_async");
                @(negedge clk_i);
                check_reset("rst_hold");
                rst_i     = 1'b0;
                mem_ack_i = 1'b0;
                model_reset();
                served = -1;
                return;
            end
            if (c == 1 && drop) begin
                if (g == 0) ibus_en_i = 1'b0;
                else        dbus_en_i = 1'b0;
            end
            mem_ack_i   = (c == lat);
            mem_rdata_i = (c == lat) ? rdata : $urandom;
            if (c == lat) break;
        end
        @(negedge clk_i);
        // Stray ack while in RESP must be ignored.
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        if (ackd) begin
            if (!(g == 1 && dwr)) begin
                if (g == 0) iexp = rdata;
                else        dexp = rdata;
            end
        end else begin
            if (g == 0) iexp = '0;
            else        dexp = '0;
            src_exp = (g == 1);
        end
        check_eq("resp_irdy", ibus_ready_o, (g == 0));
        check_eq("resp_drdy", dbus_ready_o, (g == 1));
        check_eq("resp_err", bus_error_o, !ackd);
        check_eq("resp_src", bus_error_src_o, src_exp);
        check_eq("resp_req", mem_req_o, 0);
        check_eq("resp_idata", ibus_data_o, iexp);
        check_eq("resp_ddata", dbus_data_o, dexp);
        got = (g == 0) ? ibus_data_o : dbus_data_o;
        check_eq("sb_data", got, exp_q.pop_front());
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        check_eq("post_rdy", {ibus_ready_o, dbus_ready_o}, 0);
        check_eq("post_err", bus_error_o, 0);
        check_eq("post_req", mem_req_o, 0);
        check_eq("post_idata", ibus_data_o, iexp);
        check_eq("post_ddata", dbus_data_o, dexp);
    endtask

    logic          pi, pd, pdwr;
    logic [AW-1:0] ia, da;
    logic [3:0]    pbsel;
    logic [DW-1:0] pwdata;
    int            srv;

    initial begin
        rst_i          = 1'b1;
        ibus_en_i      = 1'b0;
        ibus_addr_i    = '0;
        dbus_en_i      = 1'b0;
        dbus_addr_i    = '0;
        dbus_wr_i      = 1'b0;
        dbus_bytesel_i = '0;
        dbus_wdata_i   = '0;
        mem_ack_i      = 1'b0;
        mem_rdata_i    = '0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset("reset");
        rst_i = 1'b0;

        // Contention with immediate acks: I, D, I, D.
        for (int k = 0; k < 4; k++) begin
            run_round(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 4'hF, '0,
                      1, 32'hA5A5_0000 + k, 1'b0, 0, srv);
            check_eq("alt_grant", srv, k % 2);
        end
        // Lone instruction read, ack on the 4th BUSY cycle (the timeout cycle).
        run_round(1'b1, 32'h0000_1000, 1'b0, '0, 1'b0, 4'h0, '0,
                  4, 32'hDEAD_BEEF, 1'b0, 0, srv);
        // Data write with en dropped in BUSY.
        run_round(1'b0, '0, 1'b1, 32'h0000_5000, 1'b1, 4'b0011, 32'h1234_5678,
                  2, 32'hFFFF_FFFF, 1'b1, 0, srv);
        // Data read that memory never acknowledges.
        run_round(1'b0, '0, 1'b1, 32'h0000_2000, 1'b0, 4'hF, '0,
                  TMO + 3, 32'h0, 1'b0, 0, srv);
        // Reset in BUSY, then contention must favour I again.
        run_round(1'b1, 32'h0000_3000, 1'b1, 32'h0000_4000, 1'b0, 4'hF, '0,
                  3, 32'h1111_2222, 1'b0, 2, srv);
        run_round(1'b1, 32'h0000_3000, 1'b1, 32'h0000_4000, 1'b0, 4'hF, '0,
                  1, 32'h3333_4444, 1'b0, 0, srv);
        check_eq("post_rst_grant", srv, 0);

        // Randomized rounds; an unserved requester keeps its operands.
        pi = 1'b0;
        pd = 1'b0;
        for (int r = 0; r < 150; r++) begin
            if (!pi) begin
                pi = ($urandom_range(0, 2) != 0);
                ia = $urandom;
            end
            if (!pd) begin
                pd     = ($urandom_range(0, 2) != 0);
                da     = $urandom;
                pdwr   = 1'($urandom_range(0, 1));
                pbsel  = 4'($urandom_range(1, 15));
                pwdata = $urandom;
            end
            run_round(pi, ia, pd, da, pdwr, pbsel, pwdata,
                      $urandom_range(1, TMO + 2), $urandom,
                      ($urandom_range(0, 7) == 0), 0, srv);
            if (srv == 0)      pi = 1'b0;
            else if (srv == 1) pd = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
